// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the PRBS generator and its matching checker.
//   LFSR_W      : word / state width of the PRBS LFSR
//   CNT_W       : width of the burst and gap counters
//   fsm_state_t : generator FSM states {IDLE, RUN, GAP}
//   lfsr_next() : one step of the modified x^8+x^4+x^3+x^2+1 LFSR. The
//                 s[6:0]==0 term splices the all-zero state in between
//                 0x80 and 0x1D, so every one of the 256 states is visited
//                 and no seed can lock the register up.
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } fsm_state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      logic w_fb;
      w_fb = s[7] ^ (s[6:0] == 7'd0);
      return {s[6], s[5], s[4], s[3] ^ w_fb, s[2] ^ w_fb, s[1] ^ w_fb, s[0], w_fb};
   endfunction

endpackage

// File: rtl/lfsr_burst_timer.sv
// -----------------------------------------------------------------------------
// lfsr_burst_timer
// Burst and gap counters for the PRBS generator.
//   clk         in   clock
//   i_rst_n     in   asynchronous active-low reset
//   i_clear     in   generator idle: restart the burst count
//   i_accept    in   a word was accepted this cycle
//   i_in_gap    in   generator is currently in its idle gap
//   o_go_gap    out  this accept completes the burst (combinational)
//   o_gap_done  out  last cycle of the gap (combinational)
// With BURST_LEN = 0 the burst never ends and o_go_gap stays low.
// -----------------------------------------------------------------------------
module lfsr_burst_timer
   import lfsr_pkg::*;
#(
   parameter int BURST_LEN = 0,
   parameter int GAP_LEN   = 4
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_accept,
   input  logic i_in_gap,
   output logic o_go_gap,
   output logic o_gap_done
);

   localparam logic             BURST_EN   = (BURST_LEN != 0);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] BURST_LAST = (BURST_LEN > 0) ? CNT_W'(BURST_LEN - 1) : CNT_ZERO;
   localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_LEN > 1) ? CNT_W'(GAP_LEN - 1) : CNT_ZERO;

   logic [CNT_W-1:0] r_burst_cnt;
   logic [CNT_W-1:0] r_gap_cnt;
   logic             w_burst_last;
   logic             w_gap_last;

   assign w_burst_last = (r_burst_cnt == BURST_LAST);
   assign w_gap_last   = (r_gap_cnt == GAP_LAST);
   assign o_go_gap     = i_accept & BURST_EN & w_burst_last;
   assign o_gap_done   = i_in_gap & w_gap_last;

   // Words accepted in the current burst; wraps to zero when the burst ends.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_burst_cnt <= CNT_ZERO;
      end else if (i_clear) begin
         r_burst_cnt <= CNT_ZERO;
      end else if (i_accept) begin
         if (BURST_EN && w_burst_last) begin
            r_burst_cnt <= CNT_ZERO;
         end else begin
            r_burst_cnt <= r_burst_cnt + CNT_ONE;
         end
      end else begin
         r_burst_cnt <= r_burst_cnt;
      end
   end

   // Idle cycles spent in the current gap; held at zero outside the gap.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gap_cnt <= CNT_ZERO;
      end else if (!i_in_gap) begin
         r_gap_cnt <= CNT_ZERO;
      end else if (w_gap_last) begin
         r_gap_cnt <= CNT_ZERO;
      end else begin
         r_gap_cnt <= r_gap_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/lfsr_generator.sv
// -----------------------------------------------------------------------------
// lfsr_generator
// Transmit-side PRBS source: 8-bit words of the modified x^8+x^4+x^3+x^2+1
// LFSR (period 256) on a valid/ready stream, with optional bursting.
//   clk           in   clock, rising edge
//   i_rst_n       in   asynchronous active-low reset
//   i_start       in   pulse: leave IDLE and start streaming
//   i_stop        in   pulse: return to IDLE after the current word is accepted
//   i_load_seed   in   pulse: load i_seed into the LFSR state
//   i_seed        in   seed value
//   i_ready       in   downstream ready
//   i_inject_err  in   (LFSR_ERR_INJECT_EN only) arm a one-word bit-0 error
//   o_valid       out  o_lfsr holds a valid word
//   o_lfsr        out  current word (registered LFSR state)
//   o_wrap        out  one-cycle pulse after every 256th accepted word
//   o_busy        out  FSM not in IDLE
// Optional feature macro: LFSR_ERR_INJECT_EN.
// -----------------------------------------------------------------------------
module lfsr_generator
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = 8'hFF,
   parameter int                BURST_LEN    = 0,
   parameter int                GAP_LEN      = 4
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_load_seed,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_ready,
`ifdef LFSR_ERR_INJECT_EN
   input  logic              i_inject_err,
`endif
   output logic              o_valid,
   output logic [LFSR_W-1:0] o_lfsr,
   output logic              o_wrap,
   output logic              o_busy
);

   fsm_state_t        r_state;
   fsm_state_t        w_next_state;
   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] w_lfsr_nxt;
   logic [7:0]        r_word_cnt;
   logic              r_valid;
   logic              r_busy;
   logic              r_wrap;
   logic              r_stop_pend;
   logic              w_accept;
   logic              w_stop_now;
   logic              w_go_gap;
   logic              w_gap_done;

   assign w_accept   = r_valid & i_ready;
   assign w_stop_now = r_stop_pend | i_stop;

   lfsr_burst_timer #(
      .BURST_LEN (BURST_LEN),
      .GAP_LEN   (GAP_LEN)
   ) u_burst_timer (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (r_state == IDLE),
      .i_accept   (w_accept),
      .i_in_gap   (r_state == GAP),
      .o_go_gap   (w_go_gap),
      .o_gap_done (w_gap_done)
   );

   // Next-state logic: stop wins over start in IDLE and over a burst end in RUN.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (i_start && !i_stop) begin
               w_next_state = RUN;
            end else begin
               w_next_state = IDLE;
            end
         end
         RUN: begin
            if (w_accept) begin
               if (w_stop_now) begin
                  w_next_state = IDLE;
               end else if (w_go_gap) begin
                  w_next_state = GAP;
               end else begin
                  w_next_state = RUN;
               end
            end else begin
               w_next_state = RUN;
            end
         end
         GAP: begin
            if (i_stop) begin
               w_next_state = IDLE;
            end else if (w_gap_done) begin
               w_next_state = RUN;
            end else begin
               w_next_state = GAP;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // FSM state register with valid/busy registered alongside so they align with the state.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_valid <= (w_next_state == RUN);
         r_busy  <= (w_next_state != IDLE);
      end
   end

   // Sticky stop: a pulse seen while stalled in RUN is remembered until the word goes out.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stop_pend <= 1'b0;
      end else if ((r_state == RUN) && (w_next_state == RUN)) begin
         r_stop_pend <= w_stop_now;
      end else begin
         r_stop_pend <= 1'b0;
      end
   end

   // LFSR next value: a seed load takes priority over the advance from an accept.
   always_comb begin
      w_lfsr_nxt = r_lfsr;
      if (i_load_seed) begin
         w_lfsr_nxt = i_seed;
      end else if (w_accept) begin
         w_lfsr_nxt = lfsr_next(r_lfsr);
      end else begin
         w_lfsr_nxt = r_lfsr;
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= SEED_DEFAULT;
      end else begin
         r_lfsr <= w_lfsr_nxt;
      end
   end

   // Accepted-word counter; wrap pulse is registered so it lands the cycle after 255->0.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word_cnt <= 8'd0;
         r_wrap     <= 1'b0;
      end else if (i_load_seed) begin
         r_word_cnt <= 8'd0;
         r_wrap     <= 1'b0;
      end else if (w_accept) begin
         r_word_cnt <= r_word_cnt + 8'd1;
         r_wrap     <= (r_word_cnt == 8'hFF);
      end else begin
         r_word_cnt <= r_word_cnt;
         r_wrap     <= 1'b0;
      end
   end

`ifdef LFSR_ERR_INJECT_EN
   logic              r_inj_arm;
   logic              w_inj_arm_nxt;
   logic [LFSR_W-1:0] r_lfsr_out;

   // One-shot error arm: set by the pulse, consumed by the next accept.
   always_comb begin
      w_inj_arm_nxt = r_inj_arm;
      if (i_inject_err) begin
         w_inj_arm_nxt = 1'b1;
      end else if (w_accept) begin
         w_inj_arm_nxt = 1'b0;
      end else begin
         w_inj_arm_nxt = r_inj_arm;
      end
   end

   // Output word register: the error only touches the output copy, never the LFSR state,
   // so the sequence resumes correctly after the corrupted word.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inj_arm  <= 1'b0;
         r_lfsr_out <= SEED_DEFAULT;
      end else begin
         r_inj_arm  <= w_inj_arm_nxt;
         r_lfsr_out <= w_lfsr_nxt ^ {7'd0, w_inj_arm_nxt};
      end
   end

   assign o_lfsr = r_lfsr_out;
`else
   assign o_lfsr = r_lfsr;
`endif

   assign o_valid = r_valid;
   assign o_wrap  = r_wrap;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_lfsr_generator.sv
// -----------------------------------------------------------------------------
// tb_lfsr_generator
// Directed + randomized-ready bench for lfsr_generator. Two instances: a
// continuous one (dut) and a bursting one (dut_b, BURST_LEN=4, GAP_LEN=3).
// The reference word sequence is computed as multiplication by x in
// GF(2)[x]/(x^8+x^4+x^3+x^2+1), with 0x00 spliced between 0x80 and 0x1D.
// -----------------------------------------------------------------------------
module tb_lfsr_generator;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // continuous instance
   logic       i_rst_n, i_start, i_stop, i_load_seed, i_ready, i_inject_err;
   logic [7:0] i_seed;
   logic       o_valid, o_wrap, o_busy;
   logic [7:0] o_lfsr;

   // bursting instance
   logic       b_rst_n, b_start, b_stop, b_load, b_ready, b_inject_err;
   logic [7:0] b_seed;
   logic       b_valid, b_wrap, b_busy;
   logic [7:0] b_lfsr;

   lfsr_generator dut (
      .clk          (clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .i_load_seed  (i_load_seed),
      .i_seed       (i_seed),
      .i_ready      (i_ready),
`ifdef LFSR_ERR_INJECT_EN
      .i_inject_err (i_inject_err),
`endif
      .o_valid      (o_valid),
      .o_lfsr       (o_lfsr),
      .o_wrap       (o_wrap),
      .o_busy       (o_busy)
   );

   lfsr_generator #(.SEED_DEFAULT(8'hFF), .BURST_LEN(4), .GAP_LEN(3)) dut_b (
      .clk          (clk),
      .i_rst_n      (b_rst_n),
      .i_start      (b_start),
      .i_stop       (b_stop),
      .i_load_seed  (b_load),
      .i_seed       (b_seed),
      .i_ready      (b_ready),
`ifdef LFSR_ERR_INJECT_EN
      .i_inject_err (b_inject_err),
`endif
      .o_valid      (b_valid),
      .o_lfsr       (b_lfsr),
      .o_wrap       (b_wrap),
      .o_busy       (b_busy)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_w;
   logic [7:0] bexp_w;
   logic       acc;
   logic       exp_v;
   int         acc_cnt, wraps, wrap_at, cyc, gap_left, inburst;

   function automatic logic [7:0] ref_next(input logic [7:0] s);
      logic [8:0] t;
      if (s == 8'h80) return 8'h00;
      if (s == 8'h00) return 8'h1D;
      t = {s, 1'b0};
      if (t[8]) t = t ^ 9'h11D;
      return t[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_load_seed = 1'b0;
      i_seed = 8'h00; i_ready = 1'b0; i_inject_err = 1'b0;
      b_rst_n = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_load = 1'b0;
      b_seed = 8'h00; b_ready = 1'b0; b_inject_err = 1'b0;
      tick(); tick();
      i_rst_n = 1'b1; b_rst_n = 1'b1;
      tick();

      // reset state
      check("rst_valid", o_valid, 1'b0);
      check("rst_lfsr", o_lfsr, 8'hFF);
      check("rst_busy", o_busy, 1'b0);
      check("rst_wrap", o_wrap, 1'b0);
      check("rst_b_valid", b_valid, 1'b0);
      check("rst_b_lfsr", b_lfsr, 8'hFF);

      // stop alone and start+stop in IDLE leave it idle
      i_stop = 1'b1; tick(); i_stop = 1'b0;
      check("idle_stop_busy", o_busy, 1'b0);
      i_start = 1'b1; i_stop = 1'b1; tick(); i_start = 1'b0; i_stop = 1'b0;
      check("start_stop_busy", o_busy, 1'b0);
      check("start_stop_valid", o_valid, 1'b0);

      // seed 0x80 -> 0x80, 0x00, 0x1D
      i_load_seed = 1'b1; i_seed = 8'h80; tick(); i_load_seed = 1'b0;
      check("load_lfsr", o_lfsr, 8'h80);
      check("load_idle_valid", o_valid, 1'b0);
      i_start = 1'b1; i_ready = 1'b1; tick(); i_start = 1'b0;
      check("start_valid", o_valid, 1'b1);
      check("start_busy", o_busy, 1'b1);
      check("seq0", o_lfsr, 8'h80);
      tick();
      check("seq1", o_lfsr, 8'h00);
      tick();
      check("seq2", o_lfsr, 8'h1D);
      exp_w = 8'h1D;

      // ready low five cycles: valid held, word frozen, nothing skipped
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", o_valid, 1'b1);
         check("stall_word", o_lfsr, exp_w);
      end
      i_ready = 1'b1; tick();
      exp_w = ref_next(exp_w);
      check("after_stall", o_lfsr, exp_w);

      // random ready stream
      for (int i = 0; i < 200; i++) begin
         check("stream_valid", o_valid, 1'b1);
         check("stream_word", o_lfsr, exp_w);
         i_ready = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
         acc = o_valid & i_ready;
         tick();
         if (acc) exp_w = ref_next(exp_w);
      end

      // seed load while stalled is legal; zero seed continues to 0x1D
      i_ready = 1'b0; i_load_seed = 1'b1; i_seed = 8'h00; tick(); i_load_seed = 1'b0;
      check("stall_load_valid", o_valid, 1'b1);
      check("stall_load_word", o_lfsr, 8'h00);
      i_ready = 1'b1; tick();
      check("zero_next", o_lfsr, 8'h1D);
      exp_w = 8'h1D;

      // stop while stalled: one more accept, then IDLE
      i_ready = 1'b0; i_stop = 1'b1; tick(); i_stop = 1'b0;
      tick();
      check("stop_hold_valid", o_valid, 1'b1);
      check("stop_hold_word", o_lfsr, exp_w);
      i_ready = 1'b1; tick();
      exp_w = ref_next(exp_w);
      check("stop_valid", o_valid, 1'b0);
      check("stop_busy", o_busy, 1'b0);
      check("stop_word", o_lfsr, exp_w);
      tick();
      check("stop_stays", o_valid, 1'b0);

      // reset mid-stream: output drops immediately, state back to default
      i_start = 1'b1; tick(); i_start = 1'b0;
      tick();
      i_rst_n = 1'b0; #1;
      check("midrst_valid", o_valid, 1'b0);
      check("midrst_lfsr", o_lfsr, 8'hFF);
      check("midrst_busy", o_busy, 1'b0);
      i_rst_n = 1'b1;
      tick();

      // 256 accepts from default seed with random ready: one wrap, word 257 == 0xFF
      exp_w = 8'hFF; acc_cnt = 0; wraps = 0; wrap_at = -1; cyc = 0;
      i_start = 1'b1; tick(); i_start = 1'b0;
      while (acc_cnt < 256 && cyc < 2000) begin
         i_ready = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
         acc = o_valid & i_ready;
         if (acc) check("wrap_seq_word", o_lfsr, exp_w);
         tick(); cyc++;
         if (acc) begin
            acc_cnt++;
            exp_w = ref_next(exp_w);
         end
         if (o_wrap) begin
            wraps++;
            wrap_at = acc_cnt;
         end
      end
      check("wrap_accepts", acc_cnt, 256);
      check("wrap_pulses", wraps, 1);
      check("wrap_position", wrap_at, 256);
      check("word257", o_lfsr, 8'hFF);
      i_ready = 1'b0; tick();
      check("wrap_one_cycle", o_wrap, 1'b0);

      // bursting instance: 4 accepted words, 3 idle cycles, sequence continuous
      bexp_w = 8'hFF; gap_left = 0; inburst = 0;
      b_start = 1'b1; tick(); b_start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         exp_v = (gap_left == 0);
         check("burst_valid", b_valid, exp_v);
         if (exp_v) check("burst_word", b_lfsr, bexp_w);
         b_ready = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
         acc = exp_v & b_ready;
         tick();
         if (acc) begin
            bexp_w = ref_next(bexp_w);
            inburst++;
            if (inburst == 4) begin
               inburst = 0;
               gap_left = 3;
            end
         end else if (!exp_v) begin
            gap_left--;
         end
      end
      b_ready = 1'b0;
      for (int i = 0; i < 4 && gap_left != 0; i++) begin
         tick();
         gap_left--;
      end
      check("burst_pre_rst_valid", b_valid, 1'b1);
      b_rst_n = 1'b0; #1;
      check("burst_rst_valid", b_valid, 1'b0);
      check("burst_rst_lfsr", b_lfsr, 8'hFF);
      check("burst_rst_busy", b_busy, 1'b0);
      b_rst_n = 1'b1;
      tick();
      check("burst_rst_idle", b_valid, 1'b0);

`ifdef LFSR_ERR_INJECT_EN
      // one-shot bit-0 error on word 0xFF, sequence resumes with 0xE3
      i_rst_n = 1'b0; tick(); i_rst_n = 1'b1; tick();
      i_inject_err = 1'b1; tick(); i_inject_err = 1'b0;
      i_start = 1'b1; i_ready = 1'b1; tick(); i_start = 1'b0;
      check("inj_word", o_lfsr, 8'hFE);
      tick();
      check("inj_next", o_lfsr, 8'hE3);
      tick();
      check("inj_after", o_lfsr, ref_next(8'hE3));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
